// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR output path.
package ddr_pkg;

    // One rising/falling bit pair: [0] leaves on the rising half, [1] on the falling half.
    typedef logic [1:0] ddr_pair_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ddr_ser_state_e;

    localparam ddr_pair_t DDR_IDLE_PAIR = 2'b00;

endpackage

// File: rtl/ddr_ser_tx.sv
// Parallel-to-DDR serializer: W-bit words in on valid/ready, one bit pair out per clock.
// A single holding register lets the next word load on the same edge the last pair
// of the current word leaves, so back-to-back words stream without an idle gap.
module ddr_ser_tx #(
    parameter int unsigned W         = 8,
    parameter bit          LSB_FIRST = 1'b0,
    parameter logic [1:0]  IDLE      = ddr_pkg::DDR_IDLE_PAIR
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] data_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic [1:0]   ddr_o,
    output logic         frame_o,
    output logic         busy_o,
    output logic         underrun_o
);

    import ddr_pkg::ddr_pair_t;
    import ddr_pkg::ddr_ser_state_e;

    localparam int unsigned NPAIR    = W / 2;
    localparam int unsigned CW       = $clog2(NPAIR);
    localparam logic [CW-1:0] CNT_LAST = CW'(NPAIR - 1);

    ddr_ser_state_e state;
    logic [W-1:0]   sr;
    logic [W-1:0]   hold;
    logic           hold_vld;
    logic [CW-1:0]  cnt;
    logic           load_c;

    // Pair that leaves first from a word, in the configured bit order.
    function automatic ddr_pair_t first_pair(input logic [W-1:0] w);
        if (LSB_FIRST) begin
            return {w[1], w[0]};
        end
        return {w[W-2], w[W-1]};
    endfunction

    // Drop the pair just emitted so the next one sits at the exit end.
    function automatic logic [W-1:0] shift2(input logic [W-1:0] w);
        if (LSB_FIRST) begin
            return w >> 2;
        end
        return w << 2;
    endfunction

    // Holding register empty is the only ready condition; no path from valid_i.
    assign ready_o = ~hold_vld;

    // A held word loads when idle or when the last pair of the current word is out.
    assign load_c = hold_vld && ((state == ddr_pkg::IDLE) || (cnt == '0));

    // Handshake capture, shifter, pair counter and state machine.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ddr_pkg::IDLE;
            sr         <= '0;
            hold       <= '0;
            hold_vld   <= 1'b0;
            cnt        <= '0;
            ddr_o      <= IDLE;
            frame_o    <= 1'b0;
            busy_o     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= 1'b0;

            if (valid_i && !hold_vld) begin
                hold     <= data_i;
                hold_vld <= 1'b1;
            end

            case (state)
                ddr_pkg::IDLE: begin
                    if (load_c) begin
                        sr       <= shift2(hold);
                        ddr_o    <= first_pair(hold);
                        cnt      <= CNT_LAST;
                        frame_o  <= 1'b1;
                        busy_o   <= 1'b1;
                        hold_vld <= 1'b0;
                        state    <= ddr_pkg::SHIFT;
                    end else begin
                        ddr_o   <= IDLE;
                        frame_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                ddr_pkg::SHIFT: begin
                    if (cnt != '0) begin
                        sr      <= shift2(sr);
                        ddr_o   <= first_pair(sr);
                        cnt     <= cnt - CW'(1);
                        frame_o <= 1'b0;
                    end else if (load_c) begin
                        sr       <= shift2(hold);
                        ddr_o    <= first_pair(hold);
                        cnt      <= CNT_LAST;
                        frame_o  <= 1'b1;
                        busy_o   <= 1'b1;
                        hold_vld <= 1'b0;
                    end else begin
                        ddr_o      <= IDLE;
                        frame_o    <= 1'b0;
                        busy_o     <= 1'b0;
                        underrun_o <= 1'b1;
                        state      <= ddr_pkg::IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_ser_tx.sv
// Scoreboard bench for ddr_ser_tx: one MSB-first instance and one LSB-first instance.
module tb_ddr_ser_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data     [2];
    logic       valid    [2];
    logic       ready    [2];
    logic [1:0] ddr      [2];
    logic       frame    [2];
    logic       busy     [2];
    logic       underrun [2];

    // Expected {frame, pair} per emitted cycle, one queue per instance.
    logic [2:0] q0[$];
    logic [2:0] q1[$];

    int checks = 0;
    int errors = 0;
    int ur_cnt [2];
    bit prev_busy [2];

    always #5 clk = ~clk;

    ddr_ser_tx #(.W(8), .LSB_FIRST(1'b0), .IDLE(2'b00)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data[0]), .valid_i(valid[0]),
        .ready_o(ready[0]), .ddr_o(ddr[0]), .frame_o(frame[0]),
        .busy_o(busy[0]), .underrun_o(underrun[0])
    );

    ddr_ser_tx #(.W(8), .LSB_FIRST(1'b1), .IDLE(2'b00)) dut_lsb (
        .clk_i(clk), .rst_i(rst), .data_i(data[1]), .valid_i(valid[1]),
        .ready_o(ready[1]), .ddr_o(ddr[1]), .frame_o(frame[1]),
        .busy_o(busy[1]), .underrun_o(underrun[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [2:0] qpop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic qpush(input int d, input logic [2:0] e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: every cycle with busy high must match the next expected pair; otherwise idle.
    always @(negedge clk) begin
        logic [2:0] e;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                prev_busy[d] = 1'b0;
            end else begin
                chk("underrun_pulse", 32'(underrun[d]), 32'(prev_busy[d] && !busy[d]));
                if (underrun[d]) ur_cnt[d]++;
                if (busy[d]) begin
                    if (qsize(d) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pair inst=%0d actual=%b required=none", d, ddr[d]);
                    end else begin
                        e = qpop(d);
                        chk("pair", 32'(ddr[d]), 32'(e[1:0]));
                        chk("frame", 32'(frame[d]), 32'(e[2]));
                    end
                end else begin
                    chk("idle_pair", 32'(ddr[d]), 32'h0);
                    chk("idle_frame", 32'(frame[d]), 32'h0);
                end
                prev_busy[d] = busy[d];
            end
        end
    end

    // Offer one word; on the accepting edge push its four expected pairs.
    task automatic send_word(input int d, input logic [7:0] w);
        int n = 0;
        @(negedge clk);
        data[d]  = w;
        valid[d] = 1'b1;
        while (!ready[d]) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout inst=%0d actual=ready_low required=ready_high", d);
                valid[d] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (d == 1) qpush(d, {k == 0, w[2*k+1], w[2*k]});
            else        qpush(d, {k == 0, w[6-2*k], w[7-2*k]});
        end
        #1;
        chk("ready_after_accept", 32'(ready[d]), 32'h0);
    endtask

    task automatic stop(input int d);
        @(negedge clk);
        valid[d] = 1'b0;
    endtask

    // Wait until all expected pairs are out and the serializer is idle again.
    task automatic drain(input int d);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            #1;
            if (qsize(d) == 0 && !busy[d]) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout inst=%0d actual=%0d_pending required=0", d, qsize(d));
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int u;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0;
            data[d]  = '0;
        end
        #12;
        chk("rst_ddr", 32'(ddr[0]), 32'h0);
        chk("rst_ready", 32'(ready[0]), 32'h1);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_underrun", 32'(underrun[0]), 32'h0);
        chk("rst_frame", 32'(frame[0]), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Quiet period after reset.
        repeat (20) begin
            @(negedge clk);
            #1;
            chk("idle_ready", 32'(ready[0]), 32'h1);
            chk("idle_busy", 32'(busy[0]), 32'h0);
        end

        // Single word, then underrun.
        u = ur_cnt[0];
        send_word(0, 8'hA5);
        stop(0);
        drain(0);
        chk("underrun_single", 32'(ur_cnt[0] - u), 32'h1);

        // Back-to-back words with valid held: no gap, one underrun at the end.
        u = ur_cnt[0];
        send_word(0, 8'hF0);
        send_word(0, 8'h0F);
        stop(0);
        drain(0);
        chk("underrun_b2b", 32'(ur_cnt[0] - u), 32'h1);

        // Three words under backpressure: twelve contiguous pairs in order.
        u = ur_cnt[0];
        send_word(0, 8'h3C);
        send_word(0, 8'h96);
        send_word(0, 8'h5A);
        stop(0);
        drain(0);
        chk("underrun_three", 32'(ur_cnt[0] - u), 32'h1);

        // Reset after pair 1 of A5 with F0 held: everything discarded immediately.
        u = ur_cnt[0];
        send_word(0, 8'hA5);
        send_word(0, 8'hF0);
        @(negedge clk);
        valid[0] = 1'b0;
        #1;
        for (int i = 0; i < 20 && q0.size() > 6; i++) begin
            @(negedge clk);
            #1;
        end
        chk("mid_word_pending", 32'(q0.size()), 32'd6);
        rst = 1'b1;
        #1;
        chk("midrst_ddr", 32'(ddr[0]), 32'h0);
        chk("midrst_ready", 32'(ready[0]), 32'h1);
        chk("midrst_busy", 32'(busy[0]), 32'h0);
        chk("midrst_frame", 32'(frame[0]), 32'h0);
        q0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1;
            chk("post_rst_ready", 32'(ready[0]), 32'h1);
            chk("post_rst_busy", 32'(busy[0]), 32'h0);
        end
        chk("underrun_rst", 32'(ur_cnt[0] - u), 32'h0);

        // LSB-first instance.
        u = ur_cnt[1];
        send_word(1, 8'hA5);
        stop(1);
        drain(1);
        chk("underrun_lsb", 32'(ur_cnt[1] - u), 32'h1);

        chk("q0_empty", 32'(q0.size()), 32'h0);
        chk("q1_empty", 32'(q1.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
